// File: rtl/pid_mc_core.sv
`default_nettype none
// ============================================================================
//  Module   : pid_mc_core
//  Purpose  : Time-multiplexed multi-channel PID engine. Oversample averaging,
//             PID with one shared multiplier, and min/max output clamping,
//             with per-channel state held in register arrays.
//  Revision : 1.0 - initial release
// ============================================================================
module pid_mc_core #(
    parameter int N_CHAN    = 8,
    parameter int W_CHAN    = 3,
    parameter int W_DIN     = 18,
    parameter int W_DOUT    = 16,
    parameter int W_COEF    = 16,
    parameter int FRAC      = 8,
    parameter int W_COMP    = 48,
    parameter int MAX_OS    = 8,
    parameter int W_WR_ADDR = 16,
    parameter int W_WR_CHAN = 16,
    parameter int W_WR_DATA = 48
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        dv_in,
    input  logic [W_CHAN-1:0]           chan_in,
    input  logic signed [W_DIN-1:0]     data_in,
    output logic                        rdy_out,
    input  logic                        wr_en,
    input  logic [W_WR_ADDR-1:0]        wr_addr,
    input  logic [W_WR_CHAN-1:0]        wr_chan,
    input  logic [W_WR_DATA-1:0]        wr_data,
    output logic                        dv_out,
    output logic [W_CHAN-1:0]           chan_out,
    output logic signed [W_DOUT-1:0]    data_out
);

    localparam int c_w_int  = W_COMP - W_COEF;   // integrator width
    localparam int c_w_isum = c_w_int + 1;       // integrator pre-saturation sum
    localparam int c_w_err  = W_DIN + 1;
    localparam int c_w_der  = W_DIN + 2;
    localparam int c_w_acc  = W_COMP + 2;
    localparam int c_w_prod = W_COEF + c_w_int;
    localparam int c_w_os   = $clog2(MAX_OS + 1);
    localparam int c_w_cnt  = MAX_OS + 1;
    localparam int c_w_sum  = W_DIN + MAX_OS;

    localparam logic [W_WR_ADDR-1:0] c_addr_sp  = W_WR_ADDR'(0);
    localparam logic [W_WR_ADDR-1:0] c_addr_kp  = W_WR_ADDR'(1);
    localparam logic [W_WR_ADDR-1:0] c_addr_ki  = W_WR_ADDR'(2);
    localparam logic [W_WR_ADDR-1:0] c_addr_kd  = W_WR_ADDR'(3);
    localparam logic [W_WR_ADDR-1:0] c_addr_os  = W_WR_ADDR'(4);
    localparam logic [W_WR_ADDR-1:0] c_addr_min = W_WR_ADDR'(5);
    localparam logic [W_WR_ADDR-1:0] c_addr_max = W_WR_ADDR'(6);
    localparam logic [W_WR_ADDR-1:0] c_addr_en  = W_WR_ADDR'(7);
    localparam logic [W_WR_ADDR-1:0] c_addr_clr = W_WR_ADDR'(8);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ACC  = 3'd1,
        ST_ERR  = 3'd2,
        ST_MP   = 3'd3,
        ST_MI   = 3'd4,
        ST_MD   = 3'd5,
        ST_OUT  = 3'd6
    } state_t;

    // Per-channel configuration
    logic signed [W_DIN-1:0]   r_cfg_sp  [N_CHAN];
    logic signed [W_COEF-1:0]  r_cfg_kp  [N_CHAN];
    logic signed [W_COEF-1:0]  r_cfg_ki  [N_CHAN];
    logic signed [W_COEF-1:0]  r_cfg_kd  [N_CHAN];
    logic [c_w_os-1:0]         r_cfg_os  [N_CHAN];
    logic signed [W_DOUT-1:0]  r_cfg_min [N_CHAN];
    logic signed [W_DOUT-1:0]  r_cfg_max [N_CHAN];
    logic [N_CHAN-1:0]         r_cfg_en;

    // Per-channel running state
    logic signed [c_w_int-1:0] r_integ [N_CHAN];
    logic signed [c_w_err-1:0] r_eprev [N_CHAN];
    logic signed [c_w_sum-1:0] r_sum   [N_CHAN];
    logic [c_w_cnt-1:0]        r_cnt   [N_CHAN];

    // Working registers of the run in flight
    state_t                    r_state;
    logic                      r_rdy;
    logic                      r_dv;
    logic [W_CHAN-1:0]         r_chan_out;
    logic signed [W_DOUT-1:0]  r_data_out;
    logic [W_CHAN-1:0]         r_ch;
    logic signed [W_DIN-1:0]   r_sample;
    logic signed [W_DIN-1:0]   r_mean;
    logic signed [c_w_err-1:0] r_err;
    logic signed [c_w_der-1:0] r_deriv;
    logic signed [c_w_int-1:0] r_integ_w;
    logic signed [W_COEF-1:0]  r_kp, r_ki, r_kd;
    logic signed [W_DOUT-1:0]  r_omin, r_omax;
    logic signed [c_w_acc-1:0] r_acc;

    logic                      w_wr_hit, w_clr_hit, w_os_hit;
    logic [W_CHAN-1:0]         w_wr_ch;
    logic [c_w_os-1:0]         w_os_wr;
    logic [2**W_CHAN-1:0]      w_chan_ok;
    logic                      w_accept;
    logic signed [c_w_sum-1:0] w_sum_next;
    logic [c_w_cnt-1:0]        w_cnt_next;
    logic                      w_os_final, w_acc_kill;
    logic signed [c_w_err-1:0] w_err;
    logic signed [c_w_der-1:0] w_deriv;
    logic signed [c_w_isum-1:0] w_isum;
    logic signed [c_w_int-1:0] w_integ_sat;
    logic signed [W_COEF-1:0]  w_mul_a;
    logic signed [c_w_int-1:0] w_mul_b;
    logic signed [c_w_prod-1:0] w_prod;
    logic signed [c_w_acc-1:0] w_y;
    logic                      w_hi;
    logic signed [W_DOUT-1:0]  w_y_out;

    assign rdy_out  = r_rdy;
    assign dv_out   = r_dv;
    assign chan_out = r_chan_out;
    assign data_out = r_data_out;

    // Config bus decode; out-of-range channels never hit
    assign w_wr_hit  = wr_en && (wr_chan < W_WR_CHAN'(N_CHAN));
    assign w_wr_ch   = wr_chan[W_CHAN-1:0];
    assign w_clr_hit = w_wr_hit && (wr_addr == c_addr_clr);
    assign w_os_hit  = w_wr_hit && (wr_addr == c_addr_os);
    assign w_os_wr   = (wr_data > W_WR_DATA'(MAX_OS)) ? c_w_os'(MAX_OS) : wr_data[c_w_os-1:0];

    // Channel index is acceptable only if it exists and is enabled
    generate
        for (genvar gi = 0; gi < 2**W_CHAN; gi++) begin : g_chan_ok
            if (gi < N_CHAN) begin : g_valid
                assign w_chan_ok[gi] = r_cfg_en[gi];
            end else begin : g_invalid
                assign w_chan_ok[gi] = 1'b0;
            end
        end
    endgenerate

    assign w_accept = (r_state == ST_IDLE) && dv_in && r_rdy && w_chan_ok[chan_in];

    // Oversample accumulation for the sample held in r_sample
    assign w_sum_next = r_sum[r_ch] + c_w_sum'(r_sample);
    assign w_cnt_next = r_cnt[r_ch] + c_w_cnt'(1);
    assign w_os_final = (w_cnt_next == (c_w_cnt'(1) << r_cfg_os[r_ch]));
    // An os_log write or clear to this channel on the ACC edge discards the sample
    assign w_acc_kill = (w_clr_hit || w_os_hit) && (w_wr_ch == r_ch);

    // Error, derivative and integrator update
    assign w_err   = c_w_err'(r_cfg_sp[r_ch]) - c_w_err'(r_mean);
    assign w_deriv = c_w_der'(w_err) - c_w_der'(r_eprev[r_ch]);
    assign w_isum  = c_w_isum'(r_integ[r_ch]) + c_w_isum'(w_err);

    // Integrator saturates on signed overflow instead of wrapping
    always_comb begin
        w_integ_sat = c_w_int'(w_isum);
        if (w_isum[c_w_isum-1] != w_isum[c_w_int-1]) begin
            w_integ_sat = w_isum[c_w_isum-1] ? {1'b1, {(c_w_int-1){1'b0}}}
                                             : {1'b0, {(c_w_int-1){1'b1}}};
        end
    end

    // Shared multiplier operand select: P*e, I*integ, D*deriv
    always_comb begin
        w_mul_a = r_kd;
        w_mul_b = c_w_int'(r_deriv);
        if (r_state == ST_MP) begin
            w_mul_a = r_kp;
            w_mul_b = c_w_int'(r_err);
        end else if (r_state == ST_MI) begin
            w_mul_a = r_ki;
            w_mul_b = r_integ_w;
        end
    end

    assign w_prod = c_w_prod'(w_mul_a) * c_w_prod'(w_mul_b);
    assign w_y    = r_acc >>> FRAC;

    // Clamp to max first, then min, so min wins when limits cross
    always_comb begin
        w_hi    = (w_y > c_w_acc'(r_omax));
        w_y_out = W_DOUT'(w_y);
        if (w_hi) begin
            w_y_out = r_omax;
        end
        if ((w_hi ? c_w_acc'(r_omax) : w_y) < c_w_acc'(r_omin)) begin
            w_y_out = r_omin;
        end
    end

    // Configuration register file
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < N_CHAN; i++) begin
                r_cfg_sp[i]  <= '0;
                r_cfg_kp[i]  <= '0;
                r_cfg_ki[i]  <= '0;
                r_cfg_kd[i]  <= '0;
                r_cfg_os[i]  <= '0;
                r_cfg_min[i] <= '0;
                r_cfg_max[i] <= '0;
            end
            r_cfg_en <= '0;
        end else if (w_wr_hit) begin
            case (wr_addr)
                c_addr_sp:  r_cfg_sp[w_wr_ch]  <= wr_data[W_DIN-1:0];
                c_addr_kp:  r_cfg_kp[w_wr_ch]  <= wr_data[W_COEF-1:0];
                c_addr_ki:  r_cfg_ki[w_wr_ch]  <= wr_data[W_COEF-1:0];
                c_addr_kd:  r_cfg_kd[w_wr_ch]  <= wr_data[W_COEF-1:0];
                c_addr_os:  r_cfg_os[w_wr_ch]  <= w_os_wr;
                c_addr_min: r_cfg_min[w_wr_ch] <= wr_data[W_DOUT-1:0];
                c_addr_max: r_cfg_max[w_wr_ch] <= wr_data[W_DOUT-1:0];
                c_addr_en:  r_cfg_en[w_wr_ch]  <= wr_data[0];
                default:    ;
            endcase
        end
    end

    // Per-channel running state; config strobes are applied last so they win
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < N_CHAN; i++) begin
                r_integ[i] <= '0;
                r_eprev[i] <= '0;
                r_sum[i]   <= '0;
                r_cnt[i]   <= '0;
            end
        end else begin
            if (r_state == ST_ACC) begin
                if (w_os_final) begin
                    r_sum[r_ch] <= '0;
                    r_cnt[r_ch] <= '0;
                end else begin
                    r_sum[r_ch] <= w_sum_next;
                    r_cnt[r_ch] <= w_cnt_next;
                end
            end
            if (r_state == ST_ERR) begin
                r_integ[r_ch] <= w_integ_sat;
                r_eprev[r_ch] <= w_err;
            end
            if (w_clr_hit) begin
                r_integ[w_wr_ch] <= '0;
                r_eprev[w_wr_ch] <= '0;
                r_sum[w_wr_ch]   <= '0;
                r_cnt[w_wr_ch]   <= '0;
            end else if (w_os_hit) begin
                r_sum[w_wr_ch] <= '0;
                r_cnt[w_wr_ch] <= '0;
            end
        end
    end

    // Sequencer: accept, accumulate, error, three MACs, clamp and output
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state    <= ST_IDLE;
            r_rdy      <= 1'b0;
            r_dv       <= 1'b0;
            r_chan_out <= '0;
            r_data_out <= '0;
            r_ch       <= '0;
            r_sample   <= '0;
            r_mean     <= '0;
            r_err      <= '0;
            r_deriv    <= '0;
            r_integ_w  <= '0;
            r_kp       <= '0;
            r_ki       <= '0;
            r_kd       <= '0;
            r_omin     <= '0;
            r_omax     <= '0;
            r_acc      <= '0;
        end else begin
            r_dv <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_ch     <= chan_in;
                        r_sample <= data_in;
                        r_rdy    <= 1'b0;
                        r_state  <= ST_ACC;
                    end else begin
                        r_rdy <= 1'b1;
                    end
                end
                ST_ACC: begin
                    if (w_acc_kill || !w_os_final) begin
                        r_rdy   <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_mean  <= W_DIN'(w_sum_next >>> r_cfg_os[r_ch]);
                        r_state <= ST_ERR;
                    end
                end
                ST_ERR: begin
                    r_kp      <= r_cfg_kp[r_ch];
                    r_ki      <= r_cfg_ki[r_ch];
                    r_kd      <= r_cfg_kd[r_ch];
                    r_omin    <= r_cfg_min[r_ch];
                    r_omax    <= r_cfg_max[r_ch];
                    r_err     <= w_err;
                    r_deriv   <= w_deriv;
                    r_integ_w <= w_integ_sat;
                    r_state   <= ST_MP;
                end
                ST_MP: begin
                    r_acc   <= c_w_acc'(w_prod);
                    r_state <= ST_MI;
                end
                ST_MI: begin
                    r_acc   <= r_acc + c_w_acc'(w_prod);
                    r_state <= ST_MD;
                end
                ST_MD: begin
                    r_acc   <= r_acc + c_w_acc'(w_prod);
                    r_state <= ST_OUT;
                end
                ST_OUT: begin
                    r_dv       <= 1'b1;
                    r_chan_out <= r_ch;
                    r_data_out <= w_y_out;
                    r_rdy      <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_rdy   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pid_mc_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pid_mc_core
//  Purpose  : Directed plus randomized bench for pid_mc_core with a
//             behavioural per-channel PID model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pid_mc_core;

    logic               clk_in = 1'b0;
    logic               rst_in;
    logic               dv_in;
    logic [2:0]         chan_in;
    logic signed [17:0] data_in;
    logic               rdy_out;
    logic               wr_en;
    logic [15:0]        wr_addr;
    logic [15:0]        wr_chan;
    logic [47:0]        wr_data;
    logic               dv_out;
    logic [2:0]         chan_out;
    logic signed [15:0] data_out;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    longint m_sp[8], m_kp[8], m_ki[8], m_kd[8], m_min[8], m_max[8];
    longint m_sum[8], m_integ[8], m_eprev[8];
    int     m_os[8], m_cnt[8];
    bit     m_en[8];

    pid_mc_core dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .dv_in    (dv_in),
        .chan_in  (chan_in),
        .data_in  (data_in),
        .rdy_out  (rdy_out),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_chan  (wr_chan),
        .wr_data  (wr_data),
        .dv_out   (dv_out),
        .chan_out (chan_out),
        .data_out (data_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input longint expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_sp[i] = 0; m_kp[i] = 0; m_ki[i] = 0; m_kd[i] = 0;
            m_min[i] = 0; m_max[i] = 0; m_sum[i] = 0; m_integ[i] = 0;
            m_eprev[i] = 0; m_os[i] = 0; m_cnt[i] = 0; m_en[i] = 0;
        end
    endtask

    task automatic cfg(input int ch, input int addr, input longint val);
        wr_en = 1'b1; wr_chan = 16'(ch); wr_addr = 16'(addr); wr_data = 48'(val);
        @(negedge clk_in);
        wr_en = 1'b0;
        if (ch < 8) begin
            case (addr)
                0: m_sp[ch]  = val;
                1: m_kp[ch]  = val;
                2: m_ki[ch]  = val;
                3: m_kd[ch]  = val;
                4: begin m_os[ch] = (val > 8) ? 8 : int'(val); m_sum[ch] = 0; m_cnt[ch] = 0; end
                5: m_min[ch] = val;
                6: m_max[ch] = val;
                7: m_en[ch]  = val[0];
                8: begin m_integ[ch] = 0; m_eprev[ch] = 0; m_sum[ch] = 0; m_cnt[ch] = 0; end
                default: ;
            endcase
        end
    endtask

    task automatic setup(input int ch, input longint sp, input longint kp, input longint ki,
                         input longint kd, input int os, input longint mn, input longint mx);
        cfg(ch, 0, sp); cfg(ch, 1, kp); cfg(ch, 2, ki); cfg(ch, 3, kd);
        cfg(ch, 4, os); cfg(ch, 5, mn); cfg(ch, 6, mx); cfg(ch, 7, 1);
    endtask

    // Send one sample and check handshake timing and any result against the model
    task automatic send(input int ch, input longint x);
        int kind, rdy_low, dv_cnt, dv_pos, wait_n;
        longint mean, e, d, acc, y, got_ch, got_y;
        wait_n = 0;
        while (rdy_out !== 1'b1 && wait_n < 20) begin
            @(negedge clk_in);
            wait_n++;
        end
        chk("rdy_before_send", rdy_out, 1);
        kind = 0; y = 0;
        if (m_en[ch]) begin
            kind = 1;
            m_sum[ch] += x;
            m_cnt[ch]++;
            if (m_cnt[ch] == (1 << m_os[ch])) begin
                kind = 2;
                mean = m_sum[ch] >>> m_os[ch];
                m_sum[ch] = 0; m_cnt[ch] = 0;
                e = m_sp[ch] - mean;
                d = e - m_eprev[ch];
                m_integ[ch] += e;
                if (m_integ[ch] > 64'sd2147483647)  m_integ[ch] = 64'sd2147483647;
                if (m_integ[ch] < -64'sd2147483648) m_integ[ch] = -64'sd2147483648;
                m_eprev[ch] = e;
                acc = m_kp[ch] * e + m_ki[ch] * m_integ[ch] + m_kd[ch] * d;
                y = acc >>> 8;
                if (y > m_max[ch]) y = m_max[ch];
                if (y < m_min[ch]) y = m_min[ch];
            end
        end
        dv_in = 1'b1; chan_in = 3'(ch); data_in = 18'(x);
        rdy_low = 0; dv_cnt = 0; dv_pos = 0; got_ch = 0; got_y = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk_in);
            dv_in = 1'b0;
            if (rdy_out !== 1'b1) rdy_low++;
            if (dv_out === 1'b1) begin
                dv_cnt++; dv_pos = k; got_ch = chan_out; got_y = data_out;
            end
        end
        chk("rdy_low_cycles", rdy_low, (kind == 2) ? 6 : kind);
        chk("dv_pulses", dv_cnt, (kind == 2) ? 1 : 0);
        if (kind == 2) begin
            chk("dv_latency", dv_pos, 7);
            chk("chan_out", got_ch, ch);
            chk("data_out", got_y, y);
        end
    endtask

    initial begin
        int wait_n, rdy_low, dv_cnt;
        rst_in = 1'b0; dv_in = 1'b0; chan_in = '0; data_in = '0;
        wr_en = 1'b0; wr_addr = '0; wr_chan = '0; wr_data = '0;
        model_reset();
        repeat (3) @(negedge clk_in);
        chk("reset_dv_out", dv_out, 0);
        chk("reset_chan_out", chan_out, 0);
        chk("reset_data_out", data_out, 0);
        chk("reset_rdy_out", rdy_out, 0);
        rst_in = 1'b1;
        @(negedge clk_in);
        chk("rdy_after_release", rdy_out, 1);

        // Proportional only
        setup(2, 1000, 512, 0, 0, 0, -32768, 32767);
        send(2, 400);
        cfg(10, 0, 0);               // out-of-range channel write: ignored
        send(2, 400);

        // Integral accumulation and clear
        setup(0, 1000, 0, 256, 0, 0, -32768, 32767);
        send(0, 900); send(0, 900); send(0, 900);
        cfg(0, 8, 0);
        send(0, 900);

        // Derivative
        setup(1, 1000, 0, 0, 256, 0, -32768, 32767);
        send(1, 0); send(1, 500);

        // Oversampling by 4
        setup(3, 0, 256, 0, 0, 2, -32768, 32767);
        send(3, 10); send(3, 20); send(3, 30); send(3, 40);

        // Clamp to max, then crossed limits where min wins
        setup(4, 1000, 256, 0, 0, 0, -32768, 100);
        send(4, 0);
        cfg(4, 5, 50); cfg(4, 6, 10);
        send(4, 0);

        // Disabled channel is dropped
        send(5, 123);

        // os_log above MAX_OS is stored as MAX_OS: 256 samples per result
        setup(7, 0, 256, 0, 0, 12, -32768, 32767);
        for (int i = 0; i < 256; i++) send(7, 4);

        // Reset during MI aborts the run and clears the integrator
        setup(6, 1000, 0, 256, 0, 0, -32768, 32767);
        send(6, 900);
        wait_n = 0;
        while (rdy_out !== 1'b1 && wait_n < 20) begin
            @(negedge clk_in);
            wait_n++;
        end
        chk("rdy_before_abort", rdy_out, 1);
        dv_in = 1'b1; chan_in = 3'd6; data_in = 18'sd900;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk_in);
            dv_in = 1'b0;
        end
        rst_in = 1'b0;
        rdy_low = 0; dv_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_in);
            if (rdy_out === 1'b0) rdy_low++;
            if (dv_out !== 1'b0) dv_cnt++;
        end
        chk("abort_rdy_low_in_reset", rdy_low, 3);
        rst_in = 1'b1;
        model_reset();
        @(negedge clk_in);
        chk("abort_rdy_after_release", rdy_out, 1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_in);
            if (dv_out !== 1'b0) dv_cnt++;
        end
        chk("abort_no_dv", dv_cnt, 0);
        setup(6, 1000, 0, 256, 0, 0, -32768, 32767);
        send(6, 900);

        // Randomized configurations and samples
        for (int ch = 0; ch < 8; ch++) begin
            longint a, b;
            a = longint'($urandom_range(0, 65535)) - 32768;
            b = longint'($urandom_range(0, 65535)) - 32768;
            if ($urandom_range(0, 3) != 0 && a > b) begin longint t; t = a; a = b; b = t; end
            setup(ch, longint'($urandom_range(0, 131071)) - 65536,
                  longint'($urandom_range(0, 65535)) - 32768,
                  longint'($urandom_range(0, 65535)) - 32768,
                  longint'($urandom_range(0, 65535)) - 32768,
                  int'($urandom_range(0, 2)), a, b);
            if ($urandom_range(0, 3) == 0) cfg(ch, 7, 0);
        end
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 15) == 0) cfg(int'($urandom_range(0, 7)), 8, 0);
            send(int'($urandom_range(0, 7)), longint'($urandom_range(0, 131071)) - 65536);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
